// File: rtl/wait_state_gen.sv
`timescale 1ns/1ps
// wait_state_gen: bus-cycle wait-state generator for the 6809 CPLD.
// It watches the nE/nQ phase clocks and the slow-region chip selects. When a
// slow region is selected it pulls nWAIT low to stretch E, using a programmed
// count per region, an optional external not-ready extension, and a timeout
// guard on that extension.
//
// Ports (all in the MHZ48 domain except nEXTWAIT and nRESET):
//   MHZ48     in   48 MHz system clock
//   nRESET    in   asynchronous active-low reset
//   nE, nQ    in   inverted 6809 E / Q from the clock block
//   nCS[3:0]  in   active-low slow-region chip selects (nCS[0] highest priority)
//   nEXTWAIT  in   asynchronous active-low external not-ready
//   nWAIT     out  registered active-low stretch request
//   TIMEOUT   out  sticky flag, set when an external wait hits TMO
module wait_state_gen #(
    parameter int unsigned WAIT0 = 4,
    parameter int unsigned WAIT1 = 2,
    parameter int unsigned WAIT2 = 8,
    parameter int unsigned WAIT3 = 0,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TMO   = 255
) (
    input  logic             MHZ48,
    input  logic             nRESET,
    input  logic             nE,
    input  logic             nQ,
    input  logic [3:0]       nCS,
    input  logic             nEXTWAIT,
    output logic             nWAIT,
    output logic             TIMEOUT
);

    localparam int unsigned TMO_W = 8;
    localparam int unsigned PRE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EXT  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               ne_d;
    logic               nq_d;
    logic               ext_s1;
    logic               ext_n;
    logic [PRE_W-1:0]   pre;
    logic [PRE_W-1:0]   pre_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [TMO_W-1:0]   tmo;
    logic [TMO_W-1:0]   tmo_nxt;
    logic               timeout_nxt;
    logic               nwait_nxt;
    logic               q_rise;
    logic               e_fall;
    logic               cs_any;
    logic               tick;
    logic [CNT_W-1:0]   sel_wait;

    // Phase-clock edge detection against the previous-cycle copies.
    assign q_rise = nq_d & ~nQ;
    assign e_fall = ~ne_d & nE;
    assign cs_any = ~(&nCS);
    assign tick   = (pre == PRE_W'(3));

    // Region select: lowest active index wins.
    always_comb begin
        sel_wait = '0;
        if (!nCS[0]) begin
            sel_wait = CNT_W'(WAIT0);
        end else if (!nCS[1]) begin
            sel_wait = CNT_W'(WAIT1);
        end else if (!nCS[2]) begin
            sel_wait = CNT_W'(WAIT2);
        end else if (!nCS[3]) begin
            sel_wait = CNT_W'(WAIT3);
        end
    end

    // State register.
    always_ff @(posedge MHZ48 or negedge nRESET) begin
        if (!nRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next datapath values; abort (all nCS high) outranks ticks.
    always_comb begin
        state_nxt   = state;
        pre_nxt     = pre;
        cnt_nxt     = cnt;
        tmo_nxt     = tmo;
        timeout_nxt = TIMEOUT;
        case (state)
            S_IDLE: begin
                pre_nxt = '0;
                if (q_rise && cs_any) begin
                    if (sel_wait != '0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = sel_wait;
                    end else if (!ext_n) begin
                        state_nxt = S_EXT;
                        tmo_nxt   = '0;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                pre_nxt = pre + PRE_W'(1);
                if (!cs_any) begin
                    state_nxt = S_HOLD;
                end else if (tick) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        if (!ext_n) begin
                            state_nxt = S_EXT;
                            tmo_nxt   = '0;
                        end else begin
                            state_nxt = S_HOLD;
                        end
                    end
                end
            end
            S_EXT: begin
                pre_nxt = pre + PRE_W'(1);
                if (!cs_any || ext_n) begin
                    state_nxt = S_HOLD;
                end else if (tick) begin
                    tmo_nxt = tmo + TMO_W'(1);
                    if (tmo_nxt == TMO_W'(TMO)) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // One wait sequence per bus cycle: only the end of E re-arms.
                pre_nxt = '0;
                if (e_fall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        nwait_nxt = ~((state_nxt == S_WAIT) || (state_nxt == S_EXT));
    end

    // Datapath, synchronizers and registered outputs.
    always_ff @(posedge MHZ48 or negedge nRESET) begin
        if (!nRESET) begin
            ne_d    <= 1'b1;
            nq_d    <= 1'b1;
            ext_s1  <= 1'b1;
            ext_n   <= 1'b1;
            pre     <= '0;
            cnt     <= '0;
            tmo     <= '0;
            nWAIT   <= 1'b1;
            TIMEOUT <= 1'b0;
        end else begin
            ne_d    <= nE;
            nq_d    <= nQ;
            ext_s1  <= nEXTWAIT;
            ext_n   <= ext_s1;
            pre     <= pre_nxt;
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
            nWAIT   <= nwait_nxt;
            TIMEOUT <= timeout_nxt;
        end
    end

endmodule
